// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF-stage, MEM-stage and memory-side signals of the
// memory port arbiter. The arbiter binds to the slave modport; the
// requesters and the memory model bind to the master modport.
interface mem_port_arbiter_if;
  // instruction fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  // load/store port (EX/MEM pipeline register)
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  // shared single-port memory
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  // pipeline freeze
  logic        stall_if;
  logic        stall_mem;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch
// and load/store. Each access is granted in IDLE, issued for one cycle,
// waited out by a down-counter, and acknowledged with a one-cycle ready
// pulse in RESP. Stalls hold the pipeline until the owning port is ready.
//
// Optional build macro ARB_RR_EN: alternate the grant on simultaneous
// IF/DM requests using a last_grant register. Without it, DM always
// wins over IF.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   S_IDLE    | no access in flight, grant decision this cycle
//   S_BUSY_IF | fetch issued, counting down to the memory data cycle
//   S_BUSY_DM | load/store issued, counting down to the data cycle
//   S_RESP    | ready pulse to the owner, requests ignored
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2   // 1..15
) (
  input  logic               clk_i,
  input  logic               reset_i,  // async, active low
  mem_port_arbiter_if.slave  arb_io
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_DM = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        dm_ready_q, dm_ready_d;

  logic        dm_req;
  logic        grant_dm;
  logic        if_ready_gated;

  assign dm_req = arb_io.dm_read | arb_io.dm_write;

`ifdef ARB_RR_EN
  // 1 = last grant went to DM, 0 = last grant went to IF
  logic last_grant_q, last_grant_d;

  // On contention, the port that did not win last time gets the memory
  assign grant_dm = dm_req & (~arb_io.if_req | ~last_grant_q);

  // Track the most recent grant for the contention tie-break
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) last_grant_q <= 1'b0;
    else          last_grant_q <= last_grant_d;
  end
`else
  assign grant_dm = dm_req;
`endif

  // Next-state and datapath decisions of the access sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (dm_req || arb_io.if_req) begin
          mem_en_d = 1'b1;
          cnt_d    = LAT_INIT;
`ifdef ARB_RR_EN
          last_grant_d = grant_dm;
`endif
          if (grant_dm) begin
            // read+write together is treated as a store
            mem_we_d    = arb_io.dm_write;
            mem_addr_d  = arb_io.dm_addr;
            mem_wdata_d = arb_io.dm_wdata;
            state_d     = S_BUSY_DM;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = arb_io.if_addr;
            mem_wdata_d = 32'd0;
            state_d     = S_BUSY_IF;
          end
        end
      end
      // The counter holds MEM_LAT in the issue cycle and reaches zero in
      // the cycle the memory presents read data; that is the capture cycle.
      S_BUSY_IF: begin
        if (cnt_q == 4'd0) begin
          // capture even if the fetch was flushed; only the pulse is gated
          if_rdata_d = arb_io.mem_rdata;
          if_ready_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_BUSY_DM: begin
        if (cnt_q == 4'd0) begin
          if (!mem_we_q) dm_rdata_d = arb_io.mem_rdata;
          dm_ready_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any access
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  // A fetch flushed while in flight must not see a ready pulse
  assign if_ready_gated = if_ready_q & arb_io.if_req;

  assign arb_io.mem_en    = mem_en_q;
  assign arb_io.mem_we    = mem_we_q;
  assign arb_io.mem_addr  = mem_addr_q;
  assign arb_io.mem_wdata = mem_wdata_q;
  assign arb_io.if_rdata  = if_rdata_q;
  assign arb_io.dm_rdata  = dm_rdata_q;
  assign arb_io.if_ready  = if_ready_gated;
  assign arb_io.dm_ready  = dm_ready_q;
  assign arb_io.stall_if  = arb_io.if_req & ~if_ready_gated;
  assign arb_io.stall_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a main instance with MEM_LAT=2 checked by an
// issue/response scoreboard, plus MEM_LAT=1 and MEM_LAT=15 instances for
// latency boundaries. Each instance has a fixed-latency memory model that
// drives junk outside the valid data cycle.
module tb_mem_port_arbiter;

  localparam int LAT0 = 2;

  typedef struct {
    int          cyc;
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_bad = 0;

  exp_t iss_q[$];
  exp_t rsp_q[$];
  logic [31:0] mdl_if = 32'd0;
  logic [31:0] mdl_dm = 32'd0;

  mem_port_arbiter_if mif[3] ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h2008_0045;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? LAT0 : ((g == 1) ? 1 : 15);
    int          iss_cyc;
    logic [31:0] iss_addr;
    bit          iss_vld;

    mem_port_arbiter #(.MEM_LAT(LAT)) dut (
      .clk_i   (clk),
      .reset_i (rst_n),
      .arb_io  (mif[g])
    );

    always @(negedge clk) begin
      if (mif[g].mem_en) begin
        iss_cyc  = cyc;
        iss_addr = mif[g].mem_addr;
        iss_vld  = 1'b1;
      end
      if (iss_vld && cyc == iss_cyc + LAT) mif[g].mem_rdata = mem_f(iss_addr);
      else                                 mif[g].mem_rdata = 32'hBAD0_0000 ^ 32'(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input logic dm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int iss_c, input bit rsp);
    exp_t e;
    e.cyc = iss_c; e.dm = dm; e.we = we; e.addr = addr; e.data = wdata;
    iss_q.push_back(e);
    if (dm) begin
      if (!we) mdl_dm = mem_f(addr);
    end else begin
      mdl_if = mem_f(addr);
    end
    if (rsp) begin
      e.cyc  = iss_c + LAT0 + 1;
      e.data = dm ? mdl_dm : mdl_if;
      rsp_q.push_back(e);
    end
  endtask

  task automatic wait_port(input bit dm, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = dm ? mif[0].dm_ready : mif[0].if_ready;
    end
    if (!hit) chk(dm ? "dm_ready_timeout" : "if_ready_timeout", 32'd0, 32'd1);
    tick();
  endtask

  // Scoreboard monitor for the main instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mif[0].mem_en) begin
        if (iss_q.size() == 0) begin
          chk("spurious_mem_en", 32'd1, 32'd0);
        end else begin
          e = iss_q.pop_front();
          chk("issue_cycle", 32'(cyc), 32'(e.cyc));
          chk("issue_addr", mif[0].mem_addr, e.addr);
          chk("issue_we", {31'd0, mif[0].mem_we}, {31'd0, e.we});
          if (e.we) chk("issue_wdata", mif[0].mem_wdata, e.data);
        end
      end
      if (mif[0].if_ready || mif[0].dm_ready) begin
        if (rsp_q.size() == 0) begin
          chk("spurious_ready", {30'd0, mif[0].if_ready, mif[0].dm_ready}, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          chk("ready_port", {30'd0, mif[0].if_ready, mif[0].dm_ready}, e.dm ? 32'd1 : 32'd2);
          chk("ready_cycle", 32'(cyc), 32'(e.cyc));
          chk("ready_rdata", e.dm ? mif[0].dm_rdata : mif[0].if_rdata, e.data);
        end
      end
    end
  end

  initial begin
    int t;
    int r1;
    int r15;
    mif[0].if_req = 0; mif[0].if_addr = 0; mif[0].dm_read = 0; mif[0].dm_write = 0;
    mif[0].dm_addr = 0; mif[0].dm_wdata = 0;
    mif[1].if_req = 0; mif[1].if_addr = 0; mif[1].dm_read = 0; mif[1].dm_write = 0;
    mif[1].dm_addr = 0; mif[1].dm_wdata = 0;
    mif[2].if_req = 0; mif[2].if_addr = 0; mif[2].dm_read = 0; mif[2].dm_write = 0;
    mif[2].dm_addr = 0; mif[2].dm_wdata = 0;

    // reset state
    #2;
    chk("rst_mem_en", {31'd0, mif[0].mem_en}, 32'd0);
    chk("rst_mem_addr", mif[0].mem_addr, 32'd0);
    chk("rst_if_ready", {31'd0, mif[0].if_ready}, 32'd0);
    chk("rst_dm_ready", {31'd0, mif[0].dm_ready}, 32'd0);
    chk("rst_dm_rdata", mif[0].dm_rdata, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // single fetch, stall_if through the wait
    t = cyc;
    mif[0].if_req = 1; mif[0].if_addr = 32'h0000_0040;
    push_acc(1'b0, 1'b0, 32'h40, 32'd0, t + 1, 1'b1);
    for (int k = 0; k <= LAT0 + 2; k++) begin
      @(negedge clk);
      chk($sformatf("stall_if_c%0d", k), {31'd0, mif[0].stall_if}, (k < LAT0 + 2) ? 32'd1 : 32'd0);
    end
    tick();
    mif[0].if_req = 0;
    chk("fetch_if_rdata", mif[0].if_rdata, 32'h2008_0005);

    // contention: DM first, IF issued once DM drops
    t = cyc;
    mif[0].if_req = 1; mif[0].if_addr = 32'h80;
    mif[0].dm_read = 1; mif[0].dm_addr = 32'h100;
    push_acc(1'b1, 1'b0, 32'h100, 32'd0, t + 1, 1'b1);
    push_acc(1'b0, 1'b0, 32'h80, 32'd0, t + 6, 1'b1);
    @(negedge clk);
    chk("stall_mem_busy", {31'd0, mif[0].stall_mem}, 32'd1);
    wait_port(1'b1, 10);
    mif[0].dm_read = 0;
    wait_port(1'b0, 10);
    mif[0].if_req = 0;

    // repeated contention: DM re-requests a store (read+write) right away
    t = cyc;
    mif[0].if_req = 1; mif[0].if_addr = 32'hC0;
    mif[0].dm_read = 1; mif[0].dm_addr = 32'h180;
    push_acc(1'b1, 1'b0, 32'h180, 32'd0, t + 1, 1'b1);
    wait_port(1'b1, 10);
    mif[0].dm_read = 1; mif[0].dm_write = 1;
    mif[0].dm_addr = 32'h200; mif[0].dm_wdata = 32'hDEAD_BEEF;
`ifdef ARB_RR_EN
    push_acc(1'b0, 1'b0, 32'hC0, 32'd0, t + 6, 1'b1);
    push_acc(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, t + 11, 1'b1);
    wait_port(1'b0, 10);
    mif[0].if_req = 0;
    wait_port(1'b1, 10);
    mif[0].dm_read = 0; mif[0].dm_write = 0;
`else
    push_acc(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, t + 6, 1'b1);
    push_acc(1'b0, 1'b0, 32'hC0, 32'd0, t + 11, 1'b1);
    wait_port(1'b1, 10);
    mif[0].dm_read = 0; mif[0].dm_write = 0;
    wait_port(1'b0, 10);
    mif[0].if_req = 0;
`endif
    chk("store_keeps_dm_rdata", mif[0].dm_rdata, mem_f(32'h180));

    // flush: fetch dropped while busy, no pulse, IDLE at T+3+MEM_LAT
    t = cyc;
    mif[0].if_req = 1; mif[0].if_addr = 32'h300;
    push_acc(1'b0, 1'b0, 32'h300, 32'd0, t + 1, 1'b0);
    repeat (2) tick();
    mif[0].if_req = 0;
    repeat (3) tick();
    mif[0].dm_read = 1; mif[0].dm_addr = 32'h340;
    push_acc(1'b1, 1'b0, 32'h340, 32'd0, t + LAT0 + 4, 1'b1);
    wait_port(1'b1, 10);
    mif[0].dm_read = 0;
    chk("flush_if_rdata", mif[0].if_rdata, mem_f(32'h300));

    // reset in the middle of a load
    t = cyc;
    mif[0].dm_read = 1; mif[0].dm_addr = 32'h400;
    push_acc(1'b1, 1'b0, 32'h400, 32'd0, t + 1, 1'b1);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_en", {31'd0, mif[0].mem_en}, 32'd0);
    chk("abort_mem_we", {31'd0, mif[0].mem_we}, 32'd0);
    chk("abort_mem_addr", mif[0].mem_addr, 32'd0);
    chk("abort_mem_wdata", mif[0].mem_wdata, 32'd0);
    chk("abort_if_rdata", mif[0].if_rdata, 32'd0);
    chk("abort_dm_rdata", mif[0].dm_rdata, 32'd0);
    chk("abort_dm_ready", {31'd0, mif[0].dm_ready}, 32'd0);
    chk("abort_if_ready", {31'd0, mif[0].if_ready}, 32'd0);
    mif[0].dm_read = 0;
    iss_q.delete();
    rsp_q.delete();
    mdl_if = 32'd0;
    mdl_dm = 32'd0;
    repeat (2) tick();
    #2;
    rst_n = 1'b1;
    repeat (4) tick();
    t = cyc;
    mif[0].if_req = 1; mif[0].if_addr = 32'h440;
    push_acc(1'b0, 1'b0, 32'h440, 32'd0, t + 1, 1'b1);
    wait_port(1'b0, 10);
    mif[0].if_req = 0;

    // latency boundaries on the MEM_LAT=1 and MEM_LAT=15 instances
    t = cyc;
    r1 = -1;
    r15 = -1;
    mif[1].if_req = 1; mif[1].if_addr = 32'h500;
    mif[2].if_req = 1; mif[2].if_addr = 32'h600;
    for (int k = 0; k < 25 && r15 < 0; k++) begin
      @(negedge clk);
      if (mif[1].if_ready && r1 < 0) begin
        r1 = cyc;
        chk("lat1_rdata", mif[1].if_rdata, mem_f(32'h500));
      end
      if (mif[2].if_ready && r15 < 0) begin
        r15 = cyc;
        chk("lat15_rdata", mif[2].if_rdata, mem_f(32'h600));
      end
      tick();
      if (r1 >= 0) mif[1].if_req = 0;
      if (r15 >= 0) mif[2].if_req = 0;
    end
    chk("lat1_ready_cycle", 32'(r1), 32'(t + 3));
    chk("lat15_ready_cycle", 32'(r15), 32'(t + 17));

    repeat (3) tick();
    chk("issue_queue_drained", 32'(iss_q.size()), 32'd0);
    chk("resp_queue_drained", 32'(rsp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
